bomb_request: RTL and testbench



---
 rtl/bomb_pkg.sv | 18 +
 rtl/bomb_req_fsm.sv | 89 ++++++++
 rtl/bomb_request.sv | 91 +++++++++
 tb/tb_bomb_request.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - grid constants, cell indexing and request-state type shared by bomb logic
package bomb_pkg;

    localparam int GRID_MIN   = 1;
    localparam int GRID_MAX   = 8;
    localparam int ROW_STRIDE = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } reqState_t;

    function automatic logic [6:0] cellIdx(input logic [3:0] x, input logic [3:0] y);
        return 7'(ROW_STRIDE * int'(x) + int'(y));
    endfunction

endpackage

// File: rtl/bomb_req_fsm.sv
// rtl/bomb_req_fsm.sv - one player's press detection, request hold and cooldown
module bomb_req_fsm
    import bomb_pkg::*;
#(
    parameter int COOLDOWN_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bombTick,
    input  logic       btn,
    input  logic       gameOver,
    input  logic       cell_ok,
    input  logic [3:0] posX,
    input  logic [3:0] posY,
    output logic [3:0] bombX,
    output logic [3:0] bombY,
    output logic       bombV,
    output logic       reject,
    output logic       acceptNow
);

    localparam int CW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    reqState_t     state;
    logic [CW-1:0] cnt;
    logic          btnPrev;
    logic          press;

    assign press     = btn & ~btnPrev;
    assign acceptNow = press & (state == IDLE) & cell_ok & ~gameOver;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            btnPrev <= 1'b0;
            bombX   <= '0;
            bombY   <= '0;
            bombV   <= 1'b0;
            reject  <= 1'b0;
        end else begin
            btnPrev <= btn;
            reject  <= 1'b0;
            if (gameOver) begin
                state  <= IDLE;
                cnt    <= '0;
                bombV  <= 1'b0;
                reject <= press;
            end else begin
                case (state)
                    IDLE: begin
                        if (acceptNow) begin
                            state <= PENDING;
                            bombX <= posX;
                            bombY <= posY;
                            bombV <= 1'b1;
                        end else begin
                            reject <= press;
                        end
                    end
                    PENDING: begin
                        reject <= press;
                        // The updater samples on this edge, so the request is consumed now.
                        if (bombTick) begin
                            bombV <= 1'b0;
                            if (COOLDOWN_TICKS == 0) begin
                                state <= IDLE;
                            end else begin
                                state <= COOLDOWN;
                                cnt   <= CW'(COOLDOWN_TICKS);
                            end
                        end
                    end
                    COOLDOWN: begin
                        reject <= press;
                        if (bombTick) begin
                            cnt <= cnt - 1'b1;
                            if (cnt == CW'(1)) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/bomb_request.sv
// rtl/bomb_request.sv - validates player fire presses and presents bomb requests to the map updater
module bomb_request
    import bomb_pkg::*;
#(
    parameter int COOLDOWN_TICKS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bombTick,
    input  logic         btnA,
    input  logic         btnB,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    input  logic [99:0]  i_curBombMap_0,
    input  logic [99:0]  i_curBombMap_1,
    input  logic [1:0]   game_state,
    output logic [3:0]   bombA_x,
    output logic [3:0]   bombA_y,
    output logic [3:0]   bombB_x,
    output logic [3:0]   bombB_y,
    output logic         bombA_v,
    output logic         bombB_v,
    output logic         rejectA,
    output logic         rejectB
);

    logic       gameOver;
    logic [6:0] idxA, idxB;
    logic       inGridA, inGridB;
    logic       occA, occB;
    logic       sameAB;
    logic       cellOkA, cellOkB;
    logic       acceptA;
    logic       unusedAcceptB;

    assign gameOver = (game_state != 2'd0);
    assign idxA     = cellIdx(playerAx, playerAy);
    assign idxB     = cellIdx(playerBx, playerBy);

    assign inGridA = (int'(playerAx) >= GRID_MIN) && (int'(playerAx) <= GRID_MAX) &&
                     (int'(playerAy) >= GRID_MIN) && (int'(playerAy) <= GRID_MAX);
    assign inGridB = (int'(playerBx) >= GRID_MIN) && (int'(playerBx) <= GRID_MAX) &&
                     (int'(playerBy) >= GRID_MIN) && (int'(playerBy) <= GRID_MAX);

    // Index is only meaningful in-grid; the inGrid term masks any off-grid lookup.
    assign occA   = i_curBombMap_0[idxA] | i_curBombMap_1[idxA];
    assign occB   = i_curBombMap_0[idxB] | i_curBombMap_1[idxB];
    assign sameAB = (playerAx == playerBx) && (playerAy == playerBy);

    assign cellOkA = ~gameOver & inGridA & ~occA &
                     ~(bombB_v & (bombB_x == playerAx) & (bombB_y == playerAy));
    // B also yields to an A request for the same cell landing in this very cycle.
    assign cellOkB = ~gameOver & inGridB & ~occB &
                     ~(bombA_v & (bombA_x == playerBx) & (bombA_y == playerBy)) &
                     ~(acceptA & sameAB);

    bomb_req_fsm #(.COOLDOWN_TICKS(COOLDOWN_TICKS)) u_fsmA (
        .clk       (clk),
        .rst       (rst),
        .bombTick  (bombTick),
        .btn       (btnA),
        .gameOver  (gameOver),
        .cell_ok   (cellOkA),
        .posX      (playerAx),
        .posY      (playerAy),
        .bombX     (bombA_x),
        .bombY     (bombA_y),
        .bombV     (bombA_v),
        .reject    (rejectA),
        .acceptNow (acceptA)
    );

    bomb_req_fsm #(.COOLDOWN_TICKS(COOLDOWN_TICKS)) u_fsmB (
        .clk       (clk),
        .rst       (rst),
        .bombTick  (bombTick),
        .btn       (btnB),
        .gameOver  (gameOver),
        .cell_ok   (cellOkB),
        .posX      (playerBx),
        .posY      (playerBy),
        .bombX     (bombB_x),
        .bombY     (bombB_y),
        .bombV     (bombB_v),
        .reject    (rejectB),
        .acceptNow (unusedAcceptB)
    );

endmodule

// File: tb/tb_bomb_request.sv
// tb/tb_bomb_request.sv - directed and random bench for bomb_request against a request-level model
module tb_bomb_request;

    localparam int CD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        bombTick;
    logic        btnA, btnB;
    logic [3:0]  playerAx, playerAy, playerBx, playerBy;
    logic [99:0] map0, map1;
    logic [1:0]  gameState;
    logic [3:0]  bombA_x, bombA_y, bombB_x, bombB_y;
    logic        bombA_v, bombB_v, rejectA, rejectB;

    always #5 clk = ~clk;

    bomb_request #(.COOLDOWN_TICKS(CD)) dut (
        .clk            (clk),
        .rst            (rst),
        .bombTick       (bombTick),
        .btnA           (btnA),
        .btnB           (btnB),
        .playerAx       (playerAx),
        .playerAy       (playerAy),
        .playerBx       (playerBx),
        .playerBy       (playerBy),
        .i_curBombMap_0 (map0),
        .i_curBombMap_1 (map1),
        .game_state     (gameState),
        .bombA_x        (bombA_x),
        .bombA_y        (bombA_y),
        .bombB_x        (bombB_x),
        .bombB_y        (bombB_y),
        .bombA_v        (bombA_v),
        .bombB_v        (bombB_v),
        .rejectA        (rejectA),
        .rejectB        (rejectB)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Model: per player, a pending flag, ticks of cooldown left, last latched cell.
    int mPend[2], mCd[2], mX[2], mY[2], mRej[2], mPrev[2];

    task automatic checkVal(input string tag, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic bit onGrid(input int x, input int y);
        return x >= 1 && x <= 8 && y >= 1 && y <= 8;
    endfunction

    function automatic bit cellFree(input int x, input int y);
        int idx;
        idx = 10 * x + y;
        return !(map0[idx] || map1[idx]);
    endfunction

    task automatic modelUpdate();
        int btn[2], px[2], py[2];
        bit press[2], ok[2], idle[2];
        btn[0] = int'(btnA);     btn[1] = int'(btnB);
        px[0]  = int'(playerAx); px[1]  = int'(playerBx);
        py[0]  = int'(playerAy); py[1]  = int'(playerBy);
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                mPend[p] = 0; mCd[p] = 0; mX[p] = 0; mY[p] = 0; mRej[p] = 0; mPrev[p] = 0;
            end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            press[p] = (btn[p] == 1) && (mPrev[p] == 0);
            idle[p]  = (mPend[p] == 0) && (mCd[p] == 0);
        end
        for (int p = 0; p < 2; p++) begin
            ok[p] = press[p] && idle[p] && gameState == 0 && onGrid(px[p], py[p]) &&
                    cellFree(px[p], py[p]) &&
                    !(mPend[1-p] == 1 && mX[1-p] == px[p] && mY[1-p] == py[p]);
        end
        if (ok[0] && px[0] == px[1] && py[0] == py[1]) ok[1] = 0;
        for (int p = 0; p < 2; p++) begin
            mRej[p] = 0;
            if (gameState != 0) begin
                mPend[p] = 0;
                mCd[p]   = 0;
                mRej[p]  = int'(press[p]);
            end else begin
                if (mPend[p] == 1) begin
                    if (bombTick) begin mPend[p] = 0; mCd[p] = CD; end
                end else if (mCd[p] > 0 && bombTick) begin
                    mCd[p]--;
                end
                if (press[p]) begin
                    if (ok[p]) begin mPend[p] = 1; mX[p] = px[p]; mY[p] = py[p]; end
                    else mRej[p] = 1;
                end
            end
            mPrev[p] = btn[p];
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelUpdate();
        #1;
        checkVal("A_v",   int'(bombA_v), mPend[0]);
        checkVal("A_x",   int'(bombA_x), mX[0]);
        checkVal("A_y",   int'(bombA_y), mY[0]);
        checkVal("A_rej", int'(rejectA), mRej[0]);
        checkVal("B_v",   int'(bombB_v), mPend[1]);
        checkVal("B_x",   int'(bombB_x), mX[1]);
        checkVal("B_y",   int'(bombB_y), mY[1]);
        checkVal("B_rej", int'(rejectB), mRej[1]);
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic tickOnce();
        bombTick = 1'b1; step();
        bombTick = 1'b0; step();
    endtask

    task automatic pressA();
        btnA = 1'b1; step();
        btnA = 1'b0; step();
    endtask

    task automatic drain();
        repeat (CD + 2) tickOnce();
    endtask

    initial begin
        int vRises;
        logic prevV;
        rst = 1'b1; bombTick = 1'b0; btnA = 1'b0; btnB = 1'b0;
        playerAx = 4'd3; playerAy = 4'd4; playerBx = 4'd7; playerBy = 4'd7;
        map0 = '0; map1 = '0; gameState = 2'd0;
        for (int p = 0; p < 2; p++) begin
            mPend[p] = 0; mCd[p] = 0; mX[p] = 0; mY[p] = 0; mRej[p] = 0; mPrev[p] = 0;
        end
        cycles(2);
        checkVal("rst_Av", int'(bombA_v), 0);
        checkVal("rst_Bx", int'(bombB_x), 0);
        rst = 1'b0;
        cycles(7);

        // Basic accept at (3,4) and consumption.
        btnA = 1'b1; step();
        checkVal("acc_v", int'(bombA_v), 1);
        checkVal("acc_x", int'(bombA_x), 3);
        checkVal("acc_y", int'(bombA_y), 4);
        btnA = 1'b0; cycles(8);
        bombTick = 1'b1; step();
        checkVal("consume_v", int'(bombA_v), 0);
        bombTick = 1'b0; step();

        // Cooldown window.
        tickOnce();
        pressA();
        tickOnce();
        pressA();
        btnA = 1'b1; bombTick = 1'b1; step();
        checkVal("cd_edge_rej", int'(rejectA), 1);
        btnA = 1'b0; bombTick = 1'b0; step();
        btnA = 1'b1; step();
        checkVal("cd_after_acc", int'(bombA_v), 1);
        btnA = 1'b0; step();
        drain();

        // Occupied cell and off-grid positions.
        map0[34] = 1'b1;
        btnA = 1'b1; step();
        checkVal("occ_rej", int'(rejectA), 1);
        btnA = 1'b0; step();
        checkVal("occ_rej_once", int'(rejectA), 0);
        map0 = '0; map1[55] = 1'b1;
        playerAx = 4'd5; playerAy = 4'd5; pressA();
        map1 = '0;
        playerAx = 4'd0; playerAy = 4'd5; pressA();
        playerAx = 4'd9; playerAy = 4'd8; pressA();

        // Same-cell contention, A wins.
        playerAx = 4'd5; playerAy = 4'd5; playerBx = 4'd5; playerBy = 4'd5;
        btnA = 1'b1; btnB = 1'b1; step();
        checkVal("tie_A_v", int'(bombA_v), 1);
        checkVal("tie_B_rej", int'(rejectB), 1);
        btnA = 1'b0; btnB = 1'b0; step();
        btnB = 1'b1; step(); btnB = 1'b0; step();
        playerBx = 4'd6; btnB = 1'b1; step(); btnB = 1'b0; step();
        drain();

        // Held button yields exactly one request.
        vRises = 0; prevV = 1'b0; btnA = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bombTick = (i % 10 == 9);
            step();
            if (bombA_v && !prevV) vRises++;
            prevV = bombA_v;
        end
        checkVal("hold_one", vRises, 1);
        btnA = 1'b0; bombTick = 1'b0; step();
        drain();

        // Press together with a tick while idle waits for the next tick.
        btnA = 1'b1; bombTick = 1'b1; step();
        checkVal("tick_press_v", int'(bombA_v), 1);
        btnA = 1'b0; bombTick = 1'b0; step();
        checkVal("tick_press_hold", int'(bombA_v), 1);
        drain();

        // Game over drops the request.
        playerAx = 4'd2; playerAy = 4'd2; pressA();
        gameState = 2'd2; step();
        checkVal("go_drop", int'(bombA_v), 0);
        pressA();
        gameState = 2'd0; step();

        // Reset while pending.
        pressA();
        rst = 1'b1; step();
        checkVal("rst_pend_v", int'(bombA_v), 0);
        checkVal("rst_pend_x", int'(bombA_x), 0);
        rst = 1'b0; step();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            btnA     = ($urandom % 3 == 0);
            btnB     = ($urandom % 3 == 0);
            bombTick = ($urandom % 4 == 0);
            gameState = ($urandom % 60 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rst      = ($urandom % 400 == 0);
            if ($urandom % 6 == 0) begin
                playerAx = 4'($urandom_range(0, 9)); playerAy = 4'($urandom_range(0, 9));
            end
            if ($urandom % 6 == 0) begin
                if ($urandom % 2 == 0) begin playerBx = playerAx; playerBy = playerAy; end
                else begin playerBx = 4'($urandom_range(0, 9)); playerBy = 4'($urandom_range(0, 9)); end
            end
            if (i % 50 == 0) begin
                map0 = '0; map1 = '0;
                repeat (6) map0[$urandom_range(0, 99)] = 1'b1;
                repeat (6) map1[$urandom_range(0, 99)] = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
